// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
//   MIPS_WORD   : architectural word width in bits.
//   clz_state_t : control states of the leading-bit counter (clz_normalizer).
package mips_pkg;

  localparam int MIPS_WORD = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } clz_state_t;

endpackage

// File: rtl/clz_normalizer.sv
// Iterative count-leading-zeros/ones unit (MIPS clz/clo, mul/div normalizer).
// Scans the captured operand from the MSB, one bit per cycle, and returns the
// number of leading bits equal to the selected polarity together with the
// operand left-shifted by that amount.
//
// Ports:
//   clk         : clock
//   reset_n     : asynchronous active-low reset
//   start       : request a new operation (accepted in IDLE or DONE)
//   ones        : 0 = count leading zeros, 1 = count leading ones
//   flush       : synchronous abort, wins over start
//   a           : operand, captured with start
//   busy        : high while scanning
//   done        : one-cycle pulse when count/normalized are updated
//   count       : leading-bit count, 0..WIDTH
//   normalized  : a << count, zero-filled
module clz_normalizer
  import mips_pkg::*;
#(
  parameter int WIDTH = MIPS_WORD,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             ones,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] normalized
);

  clz_state_t       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    c_q, c_d;
  logic             o_q, o_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] norm_q, norm_d;
  logic             scan_term;
  logic             res_en;

  // The c == WIDTH term stops an all-polarity operand; otherwise the first
  // bit that differs from the latched polarity ends the scan.
  assign scan_term = (r_q[WIDTH-1] != o_q) || (c_q == CW'(WIDTH));

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    o_d     = o_q;
    res_en  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start && !flush) begin
          r_d     = a;
          c_d     = '0;
          o_d     = ones;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (scan_term) begin
          res_en  = 1'b1;
          state_d = DONE;
        end else begin
          r_d = r_q << 1;
          c_d = c_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers only load on a completed (non-flushed) scan, so an
  // aborted operation leaves the previous results visible.
  always_comb begin
    count_d = count_q;
    norm_d  = norm_q;
    if (res_en) begin
      count_d = c_q;
      norm_d  = r_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      o_q     <= 1'b0;
      count_q <= '0;
      norm_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      o_q     <= o_d;
      count_q <= count_d;
      norm_q  <= norm_d;
    end
  end

  // Status outputs are pure decodes of the registered state.
  assign busy       = (state_q == SCAN);
  assign done       = (state_q == DONE);
  assign count      = count_q;
  assign normalized = norm_q;

endmodule

// File: tb/tb_clz_normalizer.sv
module tb_clz_normalizer;

  localparam int W   = 32;
  localparam int CWB = 6;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic           ones;
  logic           flush;
  logic [W-1:0]   a;
  logic           busy;
  logic           done;
  logic [CWB-1:0] count;
  logic [W-1:0]   normalized;

  int tests;
  int fails;
  int cyc;

  // Reference model: transaction-level view of the unit.
  bit          m_run;
  bit          m_done;
  int          m_rem;
  int          m_cnt;
  logic [31:0] m_norm;
  int          m_out_cnt;
  logic [31:0] m_out_norm;

  clz_normalizer #(.WIDTH(W), .CW(CWB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .ones       (ones),
    .flush      (flush),
    .a          (a),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .normalized (normalized)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lead(logic [31:0] v, logic b);
    int n;
    n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i] == b) n++;
      else break;
    end
    return n;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One clock: update the model from the inputs sampled at the edge, then
  // compare every output 1 time unit later.
  task automatic tick();
    logic        s, f, o;
    logic [31:0] av;
    @(posedge clk);
    s  = start;
    f  = flush;
    o  = ones;
    av = a;
    if (!reset_n) begin
      m_run      = 1'b0;
      m_done     = 1'b0;
      m_rem      = 0;
      m_out_cnt  = 0;
      m_out_norm = '0;
    end else if (f) begin
      m_run  = 1'b0;
      m_done = 1'b0;
    end else if (m_run) begin
      if (m_rem == 0) begin
        m_run      = 1'b0;
        m_done     = 1'b1;
        m_out_cnt  = m_cnt;
        m_out_norm = m_norm;
      end else begin
        m_rem--;
      end
    end else begin
      m_done = 1'b0;
      if (s) begin
        m_cnt  = lead(av, o);
        m_norm = (m_cnt >= 32) ? 32'h0 : (av << m_cnt);
        m_rem  = m_cnt;
        m_run  = 1'b1;
      end
    end
    #1;
    cyc++;
    check("busy", 32'(busy), 32'(m_run));
    check("done", 32'(done), 32'(m_done));
    check("count", 32'(count), 32'(m_out_cnt));
    check("normalized", normalized, m_out_norm);
  endtask

  // Issue one operation and wait for done; returns in the done cycle so a
  // following call starts back-to-back.
  task automatic op(string name, logic o, logic [31:0] av, int e_cnt,
                    logic [31:0] e_norm, int e_lat, int e_busy);
    int k;
    int nb;
    bit seen;
    ones  = o;
    a     = av;
    start = 1'b1;
    flush = 1'b0;
    tick();
    start = 1'b0;
    nb    = busy ? 1 : 0;
    seen  = 1'b0;
    k     = 0;
    while (!seen && k < 40) begin
      tick();
      k++;
      if (done) seen = 1'b1;
      else if (busy) nb++;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: done not seen in 40 cycles, required latency %0d", name, e_lat);
    end else begin
      check({name, " latency"}, 32'(k + 1), 32'(e_lat));
      check({name, " count"}, 32'(count), 32'(e_cnt));
      check({name, " normalized"}, normalized, e_norm);
      check({name, " busy cycles"}, 32'(nb), 32'(e_busy));
    end
  endtask

  initial begin
    int nd;
    tests   = 0;
    fails   = 0;
    cyc     = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    ones    = 1'b0;
    flush   = 1'b0;
    a       = '0;
    m_run = 1'b0; m_done = 1'b0; m_rem = 0; m_cnt = 0;
    m_norm = '0; m_out_cnt = 0; m_out_norm = '0;

    tick();
    tick();
    #2 reset_n = 1'b1;
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset count", 32'(count), 32'h0);
    check("reset normalized", normalized, 32'h0);
    tick();

    op("clz 80000000", 1'b0, 32'h8000_0000, 0, 32'h8000_0000, 2, 1);
    tick();
    op("clz 00010000", 1'b0, 32'h0001_0000, 15, 32'h8000_0000, 17, 16);
    tick();
    op("clz 00000000", 1'b0, 32'h0000_0000, 32, 32'h0000_0000, 34, 33);
    tick();
    op("clo FFFFFFFF", 1'b1, 32'hFFFF_FFFF, 32, 32'h0000_0000, 34, 33);
    tick();
    op("clo F0F00000", 1'b1, 32'hF0F0_0000, 4, 32'h0F00_0000, 6, 5);
    op("clz 00000001 b2b", 1'b0, 32'h0000_0001, 31, 32'h8000_0000, 33, 32);
    tick();

    // Flush in the middle of a scan.
    ones  = 1'b0;
    a     = 32'h0000_0100;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'h0);
    check("flush done", 32'(done), 32'h0);
    check("flush count held", 32'(count), 32'd31);
    check("flush normalized held", normalized, 32'h8000_0000);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) nd++;
    end
    check("no done after flush", 32'(nd), 32'h0);
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check("start+flush ignored", 32'(busy), 32'h0);
    tick();
    check("start+flush still idle", 32'(busy), 32'h0);

    // Asynchronous reset mid-scan.
    ones  = 1'b0;
    a     = 32'h0000_0100;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'h0);
    check("async reset done", 32'(done), 32'h0);
    check("async reset count", 32'(count), 32'h0);
    check("async reset normalized", normalized, 32'h0);
    tick();
    #2 reset_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) nd++;
    end
    check("no done after reset", 32'(nd), 32'h0);
    op("clz after reset", 1'b0, 32'h8000_0000, 0, 32'h8000_0000, 2, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
